bundle_parse_queue: RTL

- Stage-1 parse unit directly downstream of Fetch.
- Accepts 60-bit two-instruction bundles from Fetch (enable_i/data_i), buffers them in a small queue, and drops all-zero NOP slots.
- Issues one decoded instruction per cycle to the dependency/decode stage.
- Provides stall_o back to Fetch and honours downstream stall_i and pipeline flush.

---
 rtl/pa_pkg.sv | 53 +++++
 rtl/bundle_fifo.sv | 53 +++++
 rtl/bundle_parse_queue.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/pa_pkg.sv
// Shared definitions for the bundle parse queue: slot field layout,
// decoded-instruction record and the slot-serializer state type.
package pa_pkg;

  localparam int SLOT_W    = 30;
  localparam int BUNDLE_W  = 2 * SLOT_W;
  localparam int ENTRY_W   = BUNDLE_W + 2;

  localparam int FMT_BIT   = 29;
  localparam int BR_BIT    = 28;
  localparam int OPC_HI    = 27;
  localparam int OPC_LO    = 21;
  localparam int PRIM_HI   = 20;
  localparam int PRIM_LO   = 16;
  localparam int SEC_HI    = 15;
  localparam int SEC_LO    = 0;
  localparam int SECREG_HI = 15;
  localparam int SECREG_LO = 11;

  localparam logic [SLOT_W-1:0] NOP_SLOT = '0;

  typedef struct packed {
    logic        format;
    logic        branch;
    logic [6:0]  opcode;
    logic [4:0]  prim_reg;
    logic [4:0]  sec_reg;
    logic [15:0] imm;
  } decoded_instr_t;

  typedef enum logic {
    HEAD_SLOT0 = 1'b0,
    HEAD_SLOT1 = 1'b1
  } slot_state_e;

  // Reg-imm slots carry a 16-bit immediate; reg-reg slots only use [15:11].
  function automatic decoded_instr_t decode_slot(input logic [SLOT_W-1:0] slot);
    decoded_instr_t d;
    d.format   = slot[FMT_BIT];
    d.branch   = slot[BR_BIT];
    d.opcode   = slot[OPC_HI:OPC_LO];
    d.prim_reg = slot[PRIM_HI:PRIM_LO];
    if (slot[FMT_BIT]) begin
      d.sec_reg = '0;
      d.imm     = slot[SEC_HI:SEC_LO];
    end else begin
      d.sec_reg = slot[SECREG_HI:SECREG_LO];
      d.imm     = '0;
    end
    return d;
  endfunction

endpackage

// File: rtl/bundle_fifo.sv
// Circular bundle queue with natural pointer wrap; a push while full is
// accepted only when a pop happens on the same edge.
module bundle_fifo
  import pa_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = ENTRY_W,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_en;
  logic          pop_en;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_en  = pop && !empty;
  assign push_en = push && (!full || pop_en);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock_i) begin
    if (push_en && !reset_i && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_en) - CW'(pop_en);
    end
  end

endmodule

// File: rtl/bundle_parse_queue.sv
// Parse stage after Fetch: queues two-slot bundles, drops NOP slots and
// issues one decoded instruction per cycle with Fetch flow control.
//
// state      | meaning
// HEAD_SLOT0 | next issue comes from the head's first valid slot
// HEAD_SLOT1 | head slot0 already issued; slot1 issues next, then pop
module bundle_parse_queue
  import pa_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int STALL_SLACK = 1
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                flushBack_i,
  input  logic                enable_i,
  input  logic [BUNDLE_W-1:0] data_i,
  input  logic                stall_i,
  output logic                stall_o,
  output logic                overflow_o,
  output logic                enable_o,
  output logic                format_o,
  output logic                branch_o,
  output logic [6:0]          opcode_o,
  output logic [4:0]          primReg_o,
  output logic [4:0]          secReg_o,
  output logic [15:0]         imm_o,
  output logic                slot_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] STALL_TH = CW'(DEPTH - STALL_SLACK);

  slot_state_e        state;
  logic [SLOT_W-1:0]  in_slot0;
  logic [SLOT_W-1:0]  in_slot1;
  logic               in_v0;
  logic               in_v1;
  logic               push_req;
  logic               push_ok;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;
  logic [CW-1:0]      count_nxt;
  logic [ENTRY_W-1:0] head_entry;
  logic               head_v0;
  logic               head_v1;
  logic               sel_slot1;
  logic               last_slot;
  logic               issue;
  logic               pop;
  decoded_instr_t     dec;

  assign in_slot0 = data_i[BUNDLE_W-1:SLOT_W];
  assign in_slot1 = data_i[SLOT_W-1:0];
  assign in_v0    = (in_slot0 != NOP_SLOT);
  assign in_v1    = (in_slot1 != NOP_SLOT);

  assign head_v0  = head_entry[ENTRY_W-1];
  assign head_v1  = head_entry[ENTRY_W-2];

  // An entry is never all-NOP, so if slot0 is invalid slot1 must be valid.
  always_comb begin
    sel_slot1 = 1'b0;
    last_slot = 1'b0;
    if (state == HEAD_SLOT1) begin
      sel_slot1 = 1'b1;
      last_slot = 1'b1;
    end else if (head_v0) begin
      sel_slot1 = 1'b0;
      last_slot = !head_v1;
    end else begin
      sel_slot1 = 1'b1;
      last_slot = 1'b1;
    end
  end

  assign dec = decode_slot(sel_slot1 ? head_entry[SLOT_W-1:0]
                                     : head_entry[BUNDLE_W-1:SLOT_W]);

  assign issue     = !flushBack_i && !stall_i && !fifo_empty;
  assign pop       = issue && last_slot;
  assign push_req  = enable_i && !flushBack_i && (in_v0 || in_v1);
  assign push_ok   = push_req && (!fifo_full || pop);
  assign count_nxt = fifo_count + CW'(push_ok) - CW'(pop);

  bundle_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .flush     (flushBack_i),
    .push      (push_ok),
    .push_data ({in_v0, in_v1, data_i}),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (head_entry)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state      <= HEAD_SLOT0;
      stall_o    <= 1'b0;
      overflow_o <= 1'b0;
      enable_o   <= 1'b0;
      format_o   <= 1'b0;
      branch_o   <= 1'b0;
      opcode_o   <= '0;
      primReg_o  <= '0;
      secReg_o   <= '0;
      imm_o      <= '0;
      slot_o     <= 1'b0;
    end else if (flushBack_i) begin
      state    <= HEAD_SLOT0;
      stall_o  <= 1'b0;
      enable_o <= 1'b0;
    end else begin
      stall_o <= (count_nxt >= STALL_TH);
      if (push_req && !push_ok) overflow_o <= 1'b1;
      // Downstream stall freezes the output registers and the serializer.
      if (!stall_i) begin
        if (!fifo_empty) begin
          enable_o  <= 1'b1;
          format_o  <= dec.format;
          branch_o  <= dec.branch;
          opcode_o  <= dec.opcode;
          primReg_o <= dec.prim_reg;
          secReg_o  <= dec.sec_reg;
          imm_o     <= dec.imm;
          slot_o    <= sel_slot1;
          state     <= last_slot ? HEAD_SLOT0 : HEAD_SLOT1;
        end else begin
          enable_o <= 1'b0;
        end
      end
    end
  end

endmodule
